// File: rtl/pe_row_ctrl.sv
// Row sequencer for the 3-tap convolution PE. It builds the sliding pixel window and issues
// window beats to the PE. PE results are buffered in a credit-protected FIFO that feeds the
// output stream, and the last result of each row is tagged.
module pe_row_ctrl #(
  parameter int LEN_W     = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_cfg_we,
  input  logic [23:0]      i_cfg_w,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_s_tdata,
  input  logic             i_s_tvalid,
  output logic             o_s_tready,
  output logic [15:0]      o_m_tdata,
  output logic             o_m_tvalid,
  input  logic             i_m_tready,
  output logic             o_m_tlast,
  output logic [7:0]       o_pe_w1,
  output logic [7:0]       o_pe_w2,
  output logic [7:0]       o_pe_w3,
  output logic [23:0]      o_pe_p,
  output logic             o_pe_p_valid,
  input  logic [15:0]      i_pe_o,
  input  logic             i_pe_o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_w1, r_w2, r_w3;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_pix_cnt;
  logic [7:0]       r_win0, r_win1;
  logic [23:0]      r_pe_p;
  logic             r_pe_p_valid;
  logic             r_p_last;
  logic             r_o_last;
  logic             r_done;
  logic             r_err;

  logic [15:0]          r_fifo_data [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] r_fifo_last;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_accept;
  logic             w_last_pix;
  logic             w_credit;
  logic [CNT_W:0]   w_inflight;
  logic             w_push;
  logic             w_pop;
  logic             w_tlast_pop;

  assign w_start_ok  = (r_state == IDLE) && i_start && (i_len >= LEN_W'(3));
  assign w_start_bad = (r_state == IDLE) && i_start && (i_len <  LEN_W'(3));
  assign w_accept    = i_s_tvalid && o_s_tready;
  assign w_last_pix  = (r_pix_cnt == (r_len - LEN_W'(1)));

  // Credit counts results already queued plus both pipeline stages, never an upcoming pop.
  assign w_inflight = {1'b0, r_count} + (CNT_W+1)'(r_pe_p_valid) + (CNT_W+1)'(i_pe_o_valid);
  assign w_credit   = (w_inflight < (CNT_W+1)'(OUT_DEPTH));

  assign w_push      = i_pe_o_valid;
  assign w_pop       = o_m_tvalid && i_m_tready;
  assign w_tlast_pop = w_pop && r_fifo_last[r_rd_ptr];

  always_comb begin
    w_next     = r_state;
    o_s_tready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = FILL;
      end
      FILL: begin
        o_s_tready = 1'b1;
        if (i_s_tvalid && (r_pix_cnt == LEN_W'(1))) w_next = RUN;
      end
      RUN: begin
        o_s_tready = w_credit;
        if (i_s_tvalid && w_credit && w_last_pix) w_next = FLUSH;
      end
      FLUSH: begin
        if (w_tlast_pop) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_w1         <= '0;
      r_w2         <= '0;
      r_w3         <= '0;
      r_len        <= '0;
      r_pix_cnt    <= '0;
      r_win0       <= '0;
      r_win1       <= '0;
      r_pe_p       <= '0;
      r_pe_p_valid <= 1'b0;
      r_p_last     <= 1'b0;
      r_o_last     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && i_cfg_we) begin
        r_w1 <= i_cfg_w[23:16];
        r_w2 <= i_cfg_w[15:8];
        r_w3 <= i_cfg_w[7:0];
      end
      if (w_start_ok) begin
        r_len     <= i_len;
        r_pix_cnt <= '0;
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + LEN_W'(1);
      end
      if (w_accept) begin
        r_win0 <= r_win1;
        r_win1 <= i_s_tdata;
      end
      r_pe_p_valid <= w_accept && (r_state == RUN);
      if (w_accept && (r_state == RUN)) begin
        r_pe_p   <= {r_win0, r_win1, i_s_tdata};
        r_p_last <= w_last_pix;
      end
      // The tlast tag rides alongside the PE pipeline so it lines up with the returning result.
      r_o_last <= r_pe_p_valid && r_p_last;
      r_done   <= (r_state == FLUSH) && w_tlast_pop;
      r_err    <= w_start_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= i_pe_o;
      r_fifo_last[r_wr_ptr] <= r_o_last;
    end
  end

  assign o_m_tvalid   = (r_count != '0);
  assign o_m_tdata    = o_m_tvalid ? r_fifo_data[r_rd_ptr] : 16'h0000;
  assign o_m_tlast    = o_m_tvalid && r_fifo_last[r_rd_ptr];
  assign o_pe_w1      = r_w1;
  assign o_pe_w2      = r_w2;
  assign o_pe_w3      = r_w3;
  assign o_pe_p       = r_pe_p;
  assign o_pe_p_valid = r_pe_p_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
